// File: rtl/minterm_pipeline.sv
// minterm_pipeline: elastic pipeline evaluating y = tt[x] in sum-of-minterms form, with hit counter
// Ports: clk, reset (sync, active-high); in_valid/in_ready/x input handshake;
//   tt_we/tt_wdata truth-table load; out_valid/out_ready/y output handshake;
//   hit_cnt saturating count of delivered y=1 results; cnt_clr clears it.
// Macro MINTERM_PIPELINE_GATE_DELAY_EN adds gate delays (inv #1, AND #2, OR #4) to the evaluation.
`timescale 1ns/1ps
module minterm_pipeline #(
  parameter int N = 3,
  parameter int STAGES = 2,
  parameter logic [2**N-1:0] INIT_TT = 8'h31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      x,
  input  logic              tt_we,
  input  logic [2**N-1:0]   tt_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              y,
  output logic [15:0]       hit_cnt,
  input  logic              cnt_clr
);
  localparam int W = 2**N;
  logic [W-1:0] tt, m;
  logic [N-1:0] xn;
  logic [N-1:0] lit [W];
  logic f, stall;
  logic [STAGES-1:0] v, d;
`ifdef MINTERM_PIPELINE_GATE_DELAY_EN
  assign #1 xn = ~x;
`else
  assign xn = ~x;
`endif
  for (genvar k = 0; k < W; k++) begin : g_mt
    localparam logic [N-1:0] KV = N'(k);
    for (genvar i = 0; i < N; i++) begin : g_lit
      assign lit[k][i] = KV[i] ? x[i] : xn[i];
    end
`ifdef MINTERM_PIPELINE_GATE_DELAY_EN
    assign #2 m[k] = &lit[k];
`else
    assign m[k] = &lit[k];
`endif
  end
`ifdef MINTERM_PIPELINE_GATE_DELAY_EN
  assign #4 f = |(m & tt);
`else
  assign f = |(m & tt);
`endif
  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign out_valid = v[STAGES-1];
  assign y = d[STAGES-1];
  // Whole pipeline holds on stall; bubbles carry d=0 so an idle output reads y=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      d <= '0;
      tt <= INIT_TT;
      hit_cnt <= '0;
    end else begin
      if (tt_we) tt <= tt_wdata;
      if (!stall) begin
        v <= STAGES'({v, in_valid});
        d <= STAGES'({d, in_valid & f});
      end
      if (cnt_clr) hit_cnt <= '0;
      else if (out_valid & out_ready & y & ~&hit_cnt) hit_cnt <= hit_cnt + 16'd1;
    end
  end
endmodule

// File: doc/minterm_pipeline.md
MINTERM_PIPELINE -- requirements
Module: minterm_pipeline

Interface
REQ-001 SHALL have parameter N, default 3, meaning input vector width (legal 1..6).
REQ-002 SHALL have parameter STAGES, default 2, meaning input-to-output latency in cycles (legal 1..8).
REQ-003 SHALL have parameter INIT_TT, width 2**N, default 8'h31, meaning reset truth table; bit k = y for input value k (x[N-1] is MSB).
REQ-004 SHALL have ports: clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset (one clock, sampled on rising clk).
REQ-006 in_valid  in  1  x is valid this cycle.
REQ-007 in_ready  out  1  block accepts x this cycle.
REQ-008 x  in  N  input minterm vector.
REQ-009 tt_we  in  1  load truth table from tt_wdata.
REQ-010 tt_wdata  in  2**N  new truth table.
REQ-011 out_valid  out  1  y holds a result.
REQ-012 out_ready  in  1  downstream consumes y this cycle.
REQ-013 y  out  1  function result.
REQ-014 hit_cnt  out  16  count of delivered results with y=1.
REQ-015 cnt_clr  in  1  clear hit_cnt.

Function
REQ-016 Transfer SHALL occur on in_valid & in_ready (input side) and out_valid & out_ready (output side).
REQ-017 Pipeline SHALL be STAGES register stages, each with a valid bit; stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
REQ-018 On stall all stages SHALL hold; no data lost or duplicated; y and out_valid stable until consumed.
REQ-019 Without stall, result of an input accepted at edge t SHALL be presented (out_valid=1) exactly after edge t+STAGES-1 (first stage captures x evaluated; STAGES=1 gives y registered on acceptance edge).
REQ-020 Evaluation SHALL be y = tt[x], structured as inverters, N-input AND per minterm, OR reduction of minterms selected by tt.
REQ-021 Result SHALL use the truth table held before the accepting edge; tt_we on the same edge affects only later inputs.
REQ-022 tt_we SHALL update tt on the rising edge regardless of stall; tt_we with reset: reset wins.
REQ-023 hit_cnt SHALL increment by 1 on each output transfer with y=1, saturating at 16'hFFFF.
REQ-024 cnt_clr SHALL zero hit_cnt on the next edge; cnt_clr with simultaneous increment: clear wins (result 0).
REQ-025 Bubbles (in_valid=0) SHALL propagate as invalid stages; back-to-back inputs SHALL sustain one result per cycle.

Reset
REQ-026 On reset: all stage valid bits 0, out_valid=0, y=0, hit_cnt=0, tt=INIT_TT.
REQ-027 in_ready SHALL be 1 during and after reset (out_valid=0 implies no stall).
REQ-028 Reset mid-operation SHALL discard all in-flight results; none appear after reset deasserts.

Configuration
REQ-029 Macro MINTERM_PIPELINE_GATE_DELAY_EN: when defined, combinational evaluation SHALL carry gate-delay annotations (timescale 1ns/1ps): inverters #1, minterm ANDs #2, OR reduction #4 (7 ns total before first stage register); clk period used with it SHALL be >= 10 ns.
REQ-030 When undefined, evaluation SHALL be zero-delay; cycle behaviour SHALL be identical in both builds.

Verification
REQ-031 Defaults, reset, then x=000,100,101,111,010 back-to-back, out_ready=1 -> after 2-cycle latency y=1,1,1,0,0 on consecutive cycles; hit_cnt=3.
REQ-032 out_ready=0 for 4 cycles with 3 results in flight -> in_ready=0 while out_valid=1, y held; on release results delivered in order, none lost.
REQ-033 tt_we with tt_wdata=8'h80 on same edge as accepting x=111 -> that result y=0; next x=111 -> y=1.
REQ-034 Force hit_cnt to 16'hFFFE via y=1 stream, deliver 3 more y=1 -> hit_cnt=16'hFFFF; cnt_clr with simultaneous y=1 transfer -> hit_cnt=0.
REQ-035 Assert reset with 2 results in flight and tt modified -> out_valid=0 next cycle, tt=8'h31, no stale output after deassert.
REQ-036 N=4, STAGES=1, MINTERM_PIPELINE_GATE_DELAY_EN defined, 10 ns clock -> all 16 x values give y=INIT_TT[x] one cycle after acceptance, matching zero-delay build.
